// File: rtl/seven_seg_capture_pkg.sv
// seven_seg_capture_pkg
// Shared definitions for both ends of the two-digit multiplexed seven-segment
// bus: the sixteen hex glyphs, the digit-slot encoding carried on the select
// bit, the capture FSM state codes, and the segment encoder the stopwatch uses
// to drive the bus.
// Ports: none (package).
package seven_seg_capture_pkg;

   localparam int NUM_GLYPHS = 16;

   // Lit segments for each hex digit, ordered gfedcba (bit0 = a). The bus
   // itself is active-low, so these are the inverted bus bits.
   localparam logic [6:0] GLYPH_TABLE [NUM_GLYPHS] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   // Meaning of bus bit 7: which digit of the pair is currently shown.
   typedef enum logic {
      SLOT_MSB = 1'b0,
      SLOT_LSB = 1'b1
   } slot_e;

   // Capture FSM state codes.
   localparam logic [1:0] ST_WAIT_EDGE = 2'd0;
   localparam logic [1:0] ST_SETTLE    = 2'd1;
   localparam logic [1:0] ST_CAPTURE   = 2'd2;

   // Encoder used by the stopwatch: nibble to active-low bus segments.
   function automatic logic [6:0] encodeSegments(input logic [3:0] nibble);
      return ~GLYPH_TABLE[nibble];
   endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// seven_seg_capture_if
// Groups the multiplexed segment bus and the reassembled-value outputs.
// Signals:
//   seg   - [6:0] active-low segments a..g, [7] digit select (1 = LSB digit)
//   value - last published {msb_nibble, lsb_nibble}
//   valid - one-cycle strobe when value updates
//   err   - one-cycle strobe when a settled pattern is not a hex glyph
//   stale - level, bus has stopped multiplexing
// Modports: master drives the bus and observes results; slave is the decoder.
interface seven_seg_capture_if;

   logic [7:0] seg;
   logic [7:0] value;
   logic       valid;
   logic       err;
   logic       stale;

   modport master (
      output seg,
      input  value,
      input  valid,
      input  err,
      input  stale
   );

   modport slave (
      input  seg,
      output value,
      output valid,
      output err,
      output stale
   );

endinterface

// File: rtl/seven_seg_glyph_decode.sv
// seven_seg_glyph_decode
// Combinational lookup of a lit-segment pattern (gfedcba, active-high) back
// to its hex nibble.
// Ports:
//   seg_i    - 7-bit lit-segment pattern
//   ok_o     - pattern matches one of the sixteen glyphs
//   nibble_o - matching hex value (0 when ok_o is low)
module seven_seg_glyph_decode
   import seven_seg_capture_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic       ok_o,
   output logic [3:0] nibble_o
);

   // Search the shared glyph table; the glyphs are all distinct so at most one
   // entry can match.
   always_comb begin
      ok_o     = 1'b0;
      nibble_o = 4'd0;
      for (int i = 0; i < NUM_GLYPHS; i++) begin
         if (seg_i == GLYPH_TABLE[i]) begin
            ok_o     = 1'b1;
            nibble_o = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
// Receive-side decoder for the two-digit multiplexed seven-segment bus.
// Synchronizes the bus, waits for each digit to hold steady, decodes it and
// publishes the reassembled byte once both digits have been seen.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   bus_if - slave side of seven_seg_capture_if (seg in; value/valid/err/stale out)
// Parameters:
//   SETTLE_CYCLES  - cycles a pattern must hold before capture (>= 2)
//   TIMEOUT_CYCLES - cycles without a select edge before the bus is stale
module seven_seg_capture
   import seven_seg_capture_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic                clk_i,
   input logic                rst_i,
   seven_seg_capture_if.slave bus_if
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] SETTLE_ONE   = SW'(1);
   localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [7:0]    segMeta_q, segSync_q, segPrev_q;
   logic [1:0]    state_q, state_d;
   logic [SW-1:0] settleCnt_q, settleCnt_d;
   logic [TW-1:0] idleCnt_q, idleCnt_d;
   logic [3:0]    msbNibble_q, msbNibble_d;
   logic [3:0]    lsbNibble_q, lsbNibble_d;
   logic          haveMsb_q, haveMsb_d;
   logic          haveLsb_q, haveLsb_d;
   logic [7:0]    value_q, value_d;
   logic          valid_q, valid_d;
   logic          capErr_q, capErr_d;
   logic          err_q, err_d;
   logic          stale_q, stale_d;

   logic          selEdge;
   logic          busStable;
   logic          timeoutHit;
   logic          decOk;
   logic [3:0]    decNibble;
   logic [6:0]    decSegments;

   // segPrev_q is the settled pattern by the time CAPTURE runs, so decoding it
   // stays correct even when the next digit already arrives in that cycle.
   assign decSegments = ~segPrev_q[6:0];
   assign selEdge     = segSync_q[7] ^ segPrev_q[7];
   assign busStable   = (segSync_q == segPrev_q);
   assign timeoutHit  = !selEdge && (idleCnt_q == TIMEOUT_LAST);

   seven_seg_glyph_decode uDecode (
      .seg_i    (decSegments),
      .ok_o     (decOk),
      .nibble_o (decNibble)
   );

   // Two-flop synchronizer plus a one-cycle history of the synchronized bus.
   // These are pure data-path flops and are left out of reset so that a
   // reset never fabricates a select edge from a bus that is simply being held.
   always_ff @(posedge clk_i) begin
      segMeta_q <= bus_if.seg;
      segSync_q <= segMeta_q;
      segPrev_q <= segSync_q;
   end

   // Next-state logic. Publishing runs first so a capture in the same cycle can
   // still set its flag; the timeout runs last because it must win over both.
   // The FSM enters CAPTURE in the same step the stable count reaches
   // SETTLE_CYCLES, and a select edge seen while in CAPTURE starts the next
   // digit directly so back-to-back digits are not lost.
   always_comb begin
      state_d     = state_q;
      settleCnt_d = settleCnt_q;
      idleCnt_d   = idleCnt_q;
      msbNibble_d = msbNibble_q;
      lsbNibble_d = lsbNibble_q;
      haveMsb_d   = haveMsb_q;
      haveLsb_d   = haveLsb_q;
      value_d     = value_q;
      valid_d     = 1'b0;
      capErr_d    = 1'b0;
      err_d       = capErr_q;
      stale_d     = stale_q;

      if (selEdge) begin
         idleCnt_d = '0;
      end else if (idleCnt_q != TIMEOUT_MAX) begin
         idleCnt_d = idleCnt_q + TW'(1);
      end

      if (haveMsb_q && haveLsb_q) begin
         value_d   = {msbNibble_q, lsbNibble_q};
         valid_d   = 1'b1;
         haveMsb_d = 1'b0;
         haveLsb_d = 1'b0;
         stale_d   = 1'b0;
      end

      case (state_q)
         ST_WAIT_EDGE: begin
            if (selEdge) begin
               state_d     = ST_SETTLE;
               settleCnt_d = SETTLE_ONE;
            end
         end
         ST_SETTLE: begin
            if (!busStable) begin
               settleCnt_d = SETTLE_ONE;
            end else if (settleCnt_q == SETTLE_LAST) begin
               settleCnt_d = settleCnt_q + SW'(1);
               state_d     = ST_CAPTURE;
            end else begin
               settleCnt_d = settleCnt_q + SW'(1);
            end
         end
         ST_CAPTURE: begin
            if (slot_e'(segPrev_q[7]) == SLOT_LSB) begin
               lsbNibble_d = decOk ? decNibble : lsbNibble_q;
               haveLsb_d   = decOk;
            end else begin
               msbNibble_d = decOk ? decNibble : msbNibble_q;
               haveMsb_d   = decOk;
            end
            capErr_d = !decOk;
            if (selEdge) begin
               state_d     = ST_SETTLE;
               settleCnt_d = SETTLE_ONE;
            end else begin
               state_d     = ST_WAIT_EDGE;
               settleCnt_d = '0;
            end
         end
         default: begin
            state_d     = ST_WAIT_EDGE;
            settleCnt_d = '0;
         end
      endcase

      if (timeoutHit) begin
         stale_d     = 1'b1;
         haveMsb_d   = 1'b0;
         haveLsb_d   = 1'b0;
         state_d     = ST_WAIT_EDGE;
         settleCnt_d = '0;
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_WAIT_EDGE;
         settleCnt_q <= '0;
         idleCnt_q   <= '0;
         msbNibble_q <= 4'd0;
         lsbNibble_q <= 4'd0;
         haveMsb_q   <= 1'b0;
         haveLsb_q   <= 1'b0;
         value_q     <= 8'h00;
         valid_q     <= 1'b0;
         capErr_q    <= 1'b0;
         err_q       <= 1'b0;
         stale_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         settleCnt_q <= settleCnt_d;
         idleCnt_q   <= idleCnt_d;
         msbNibble_q <= msbNibble_d;
         lsbNibble_q <= lsbNibble_d;
         haveMsb_q   <= haveMsb_d;
         haveLsb_q   <= haveLsb_d;
         value_q     <= value_d;
         valid_q     <= valid_d;
         capErr_q    <= capErr_d;
         err_q       <= err_d;
         stale_q     <= stale_d;
      end
   end

   assign bus_if.value = value_q;
   assign bus_if.valid = valid_q;
   assign bus_if.err   = err_q;
   assign bus_if.stale = stale_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture
// Self-checking bench for seven_seg_capture: a table of held bus patterns with
// expected pulse counts and end values, hand-written stale-timing and reset
// sequences, and a randomized digit stream checked against a reference model.
module tb_seven_seg_capture;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 4096;

   logic clk = 1'b0;
   logic rst;

   seven_seg_capture_if busIf ();

   seven_seg_capture #(
      .SETTLE_CYCLES  (SETTLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_if (busIf)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Hex glyphs as lit segments gfedcba.
   localparam logic [6:0] REF_GLYPH [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   typedef struct {
      logic [7:0] seg;
      int         hold;
      int         expValid;
      int         expErr;
      logic [7:0] expValue;
      logic       expStale;
   } vec_t;

   int testsRun    = 0;
   int testsFailed = 0;

   logic       obsValid;
   logic       obsErr;
   logic       obsStale;
   logic [7:0] obsValue;

   // One cycle: at the falling edge, first record the outputs settled after
   // the previous rising edge, then drive the inputs for the next rising edge.
   task automatic applyStimulus(input logic [7:0] seg, input logic r);
      @(negedge clk);
      obsValid  = busIf.valid;
      obsErr    = busIf.err;
      obsStale  = busIf.stale;
      obsValue  = busIf.value;
      busIf.seg = seg;
      rst       = r;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic int glyphIndex(input logic [6:0] g);
      for (int i = 0; i < 16; i++) begin
         if (REF_GLYPH[i] == g) return i;
      end
      return -1;
   endfunction

   vec_t       vecs [15];
   int         nValid;
   int         nErr;
   int         seenAt;
   int         segLen;
   int         evIdx;
   int         gi;
   logic       sel;
   logic [6:0] g;
   logic [7:0] segVal;
   logic [7:0] stim [$];
   int         segStartQ [$];
   int         segLenQ [$];
   logic [7:0] segValQ [$];
   logic       expValidQ [$];
   logic       expErrQ [$];
   logic [7:0] expValQ [$];
   logic       mHaveMsb;
   logic       mHaveLsb;
   logic [3:0] mMsb;
   logic [3:0] mLsb;

   // Main sequence: reset, directed table, hand-written corner cases, then
   // the randomized stream against the reference model.
   initial begin
      busIf.seg = 8'hFF;
      rst       = 1'b1;

      vecs[0]  = '{8'h19,   10, 0, 0, 8'h00, 1'b0};
      vecs[1]  = '{8'hA4,   10, 1, 0, 8'h42, 1'b0};
      vecs[2]  = '{8'h19,   10, 0, 0, 8'h42, 1'b0};
      vecs[3]  = '{8'hA4,    2, 0, 0, 8'h42, 1'b0};
      vecs[4]  = '{8'h19,   12, 0, 0, 8'h42, 1'b0};
      vecs[5]  = '{8'hFF,   10, 0, 1, 8'h42, 1'b0};
      vecs[6]  = '{8'h10, 1024, 0, 0, 8'h42, 1'b0};
      vecs[7]  = '{8'h80, 1024, 1, 0, 8'h98, 1'b0};
      vecs[8]  = '{8'h10, 1024, 0, 0, 8'h98, 1'b0};
      vecs[9]  = '{8'h90, 1024, 1, 0, 8'h99, 1'b0};
      vecs[10] = '{8'h40, 1024, 0, 0, 8'h99, 1'b0};
      vecs[11] = '{8'hC0, 1024, 1, 0, 8'h00, 1'b0};
      vecs[12] = '{8'h19, 4200, 0, 0, 8'h00, 1'b1};
      vecs[13] = '{8'hA4,   10, 0, 0, 8'h00, 1'b1};
      vecs[14] = '{8'h19,   10, 1, 0, 8'h42, 1'b0};

      for (int i = 0; i < 4; i++) applyStimulus(8'hFF, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(8'hFF, 1'b0);
      checkOutput("reset_value", obsValue, 8'h00);
      checkOutput("reset_valid", obsValid, 1'b0);
      checkOutput("reset_err",   obsErr,   1'b0);
      checkOutput("reset_stale", obsStale, 1'b0);

      for (int v = 0; v < 15; v++) begin
         nValid = 0;
         nErr   = 0;
         for (int c = 0; c < vecs[v].hold; c++) begin
            applyStimulus(vecs[v].seg, 1'b0);
            if (c > 0) begin
               nValid += int'(obsValid);
               nErr   += int'(obsErr);
            end
         end
         checkOutput($sformatf("vec%0d_valid_count", v), nValid, vecs[v].expValid);
         checkOutput($sformatf("vec%0d_err_count", v), nErr, vecs[v].expErr);
         checkOutput($sformatf("vec%0d_value", v), obsValue, vecs[v].expValue);
         checkOutput($sformatf("vec%0d_stale", v), obsStale, vecs[v].expStale);
      end

      // Stale must rise exactly TIMEOUT cycles after the select edge reaches
      // the synchronized bus (two cycles after the pin change).
      for (int i = 0; i < 10; i++) applyStimulus(8'hA4, 1'b0);
      applyStimulus(8'h19, 1'b0);
      seenAt = -1;
      for (int k = 1; k < TIMEOUT + 40; k++) begin
         applyStimulus(8'h19, 1'b0);
         if (obsStale && seenAt < 0) seenAt = k - 1;
      end
      checkOutput("stale_edge_offset", seenAt, TIMEOUT + 2);

      // Reset while the second digit of a pair is settling.
      for (int i = 0; i < 10; i++) applyStimulus(8'hA4, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(8'h19, 1'b0);
      applyStimulus(8'h19, 1'b1);
      applyStimulus(8'h19, 1'b0);
      checkOutput("midreset_value", obsValue, 8'h00);
      checkOutput("midreset_stale", obsStale, 1'b0);
      nValid = 0;
      nErr   = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(8'h19, 1'b0);
         nValid += int'(obsValid);
         nErr   += int'(obsErr);
      end
      for (int i = 0; i < 10; i++) begin
         applyStimulus(8'hA4, 1'b0);
         if (i > 0) begin
            nValid += int'(obsValid);
            nErr   += int'(obsErr);
         end
      end
      checkOutput("midreset_no_valid", nValid, 0);
      checkOutput("midreset_no_err", nErr, 0);
      nValid = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(8'h19, 1'b0);
         if (i > 0) nValid += int'(obsValid);
      end
      checkOutput("midreset_fresh_valid", nValid, 1);
      checkOutput("midreset_fresh_value", obsValue, 8'h42);

      // Randomized stream of alternating-select digits with random hold
      // lengths and occasional non-glyph patterns.
      for (int i = 0; i < 4; i++) applyStimulus(8'hFF, 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(8'hFF, 1'b0);

      sel = 1'b0;
      for (int s = 0; s < 40; s++) begin
         segLen = $urandom_range(1, 12);
         if ($urandom_range(0, 4) == 0) begin
            g = 7'($urandom);
            while (glyphIndex(g) >= 0) g = 7'($urandom);
         end else begin
            g = REF_GLYPH[$urandom_range(0, 15)];
         end
         segVal = {sel, ~g};
         sel    = ~sel;
         if (s == 39) segLen += 12;
         segStartQ.push_back(stim.size());
         segLenQ.push_back(segLen);
         segValQ.push_back(segVal);
         for (int c = 0; c < segLen; c++) stim.push_back(segVal);
      end

      // Reference model: a digit held at the pins for at least SETTLE cycles
      // is captured, and its result shows SETTLE+3 cycles after it appeared.
      for (int i = 0; i < stim.size(); i++) begin
         expValidQ.push_back(1'b0);
         expErrQ.push_back(1'b0);
         expValQ.push_back(8'h00);
      end
      mHaveMsb = 1'b0;
      mHaveLsb = 1'b0;
      mMsb     = 4'd0;
      mLsb     = 4'd0;
      for (int s = 0; s < segStartQ.size(); s++) begin
         if (segLenQ[s] >= SETTLE) begin
            evIdx = segStartQ[s] + SETTLE + 3;
            gi    = glyphIndex(~segValQ[s][6:0]);
            if (gi < 0) begin
               expErrQ[evIdx] = 1'b1;
               if (segValQ[s][7]) mHaveLsb = 1'b0;
               else               mHaveMsb = 1'b0;
            end else begin
               if (segValQ[s][7]) begin
                  mLsb     = 4'(gi);
                  mHaveLsb = 1'b1;
               end else begin
                  mMsb     = 4'(gi);
                  mHaveMsb = 1'b1;
               end
               if (mHaveMsb && mHaveLsb) begin
                  expValidQ[evIdx] = 1'b1;
                  expValQ[evIdx]   = {mMsb, mLsb};
                  mHaveMsb         = 1'b0;
                  mHaveLsb         = 1'b0;
               end
            end
         end
      end

      for (int k = 0; k <= stim.size(); k++) begin
         applyStimulus(stim[(k < stim.size()) ? k : stim.size() - 1], 1'b0);
         if (k > 0) begin
            checkOutput($sformatf("rand_valid@%0d", k - 1), obsValid, expValidQ[k-1]);
            checkOutput($sformatf("rand_err@%0d", k - 1), obsErr, expErrQ[k-1]);
            checkOutput($sformatf("rand_exclusive@%0d", k - 1), obsValid & obsErr, 1'b0);
            if (expValidQ[k-1]) begin
               checkOutput($sformatf("rand_value@%0d", k - 1), obsValue, expValQ[k-1]);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side decoder for the two-digit multiplexed seven-segment bus that the stopwatch drives onto its Pmod output. Samples the 8-bit segment/digit-select bus, waits for each digit to settle, decodes the active-low segment patterns back to hex nibbles, and publishes the reassembled 8-bit display value with a one-cycle valid strobe. Used for on-chip loopback self-test and for reading a second board's display through the bidirectional IOs.

## Interface

- SETTLE_CYCLES, 4: consecutive cycles a pattern must be stable before capture (≥2)
- TIMEOUT_CYCLES, 4096: cycles without a digit-select edge before the bus is declared stale
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- seg_in  in  8  [6:0] active-low segments (bit0=a … bit6=g); [7] digit select: 1 = LSB digit shown, 0 = MSB digit shown
- value  out  8  last published value {msb_nibble, lsb_nibble}
- valid  out  1  one-cycle pulse when value updates
- err  out  1  one-cycle pulse when a settled pattern matches no hex glyph
- stale  out  1  level; bus stopped multiplexing

## Operation

- seg_in passes through a 2-flop synchronizer; all logic below uses the synchronized bus.
- Decode table (segments after inversion, gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, B=1111100, C=0111001, D=1011110, E=1111001, F=1110001. Any other pattern is invalid.
- FSM:
  - WAIT_EDGE (reset state): idle until synchronized select differs from its previous-cycle value → SETTLE, stable counter = 1.
  - SETTLE: counter increments while the full 8-bit bus equals the previous cycle; any change reloads counter to 1 (a select change restarts with the new digit; the old one is discarded, no err). At counter == SETTLE_CYCLES → CAPTURE.
  - CAPTURE (1 cycle): decode; valid glyph → store nibble in the MSB or LSB slot per select and set that slot's have flag; invalid → err pulse, clear that slot's flag. → WAIT_EDGE.
- Publish: in the cycle after a capture leaves both have flags set, value <= {msb, lsb}, valid = 1, both flags cleared, stale cleared.
- Timeout: counter reset on every select edge; reaching TIMEOUT_CYCLES → stale = 1, both flags cleared, FSM → WAIT_EDGE; counter saturates. stale stays set until the next publish.
- Digit order is irrelevant: MSB-then-LSB and LSB-then-MSB both publish.
- Same value published repeatedly: valid pulses each time (no change detection).

## Timing

- Reset: value = 0x00, valid = 0, err = 0, stale = 0, have flags cleared, FSM = WAIT_EDGE, all counters 0.
- RST mid-SETTLE or mid-CAPTURE: no valid/err produced for the interrupted digit; state as above next cycle.
- seg_in → synchronized bus: 2 cycles.
- Completing digit presented at seg_in edge N (and held): valid high at edge N + 2 + SETTLE_CYCLES + 1, value updated at the same edge.
- err pulse aligns with the cycle a valid pulse would have occupied.
- Pulses shorter than SETTLE_CYCLES synchronized cycles are never captured.
- valid and err are never high in the same cycle.

## Structure

- Shared package: glyph constants (16 × 7-bit), FSM state enum, slot-select encoding. The stopwatch's encoder table must move to the same package so both ends use one source.
- One sub-module: seven_seg_glyph_decode (combinational 7-bit → {ok, nibble[3:0]}); synchronizer and FSM inline.

## Test plan

- Reset then drive 0x19 (MSB "4", select 0) for 10 cycles, then 0xA4 (LSB "2", select 1) for 10 cycles → one valid pulse, value = 0x42, err = 0, stale = 0.
- Alternate MSB/LSB every 1024 cycles through display 0x98→0x99→0x00 → successive publishes 0x98, 0x99, 0x00, one valid per digit pair.
- Hold LSB 0xA4 for 2 cycles inside an MSB 0x19 stream (SETTLE_CYCLES=4) → no capture, no valid, no err.
- Settled 0xFF (select 1, all segments off) → single err pulse, no valid; prior value unchanged.
- Bus frozen at 0x19 for 4096+ cycles → stale = 1 at exactly TIMEOUT_CYCLES after the last select edge; resume multiplexing 0x42 → valid, stale = 0.
- Assert RST for one cycle during SETTLE of the second digit → value = 0x00, no valid until a fresh MSB+LSB pair completes.
